// File: rtl/wave_stream_scheduler_if.sv
// Generator strobe/sample pair plus the byte-wide valid/ready link to the UART TX.
// master = scheduler side, slave = generator/UART side.
interface wave_stream_scheduler_if;
  logic       gen_ce;
  logic [9:0] sample_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output gen_ce, tx_data, tx_valid, input  sample_in, tx_ready);
  modport slave  (input  gen_ce, tx_data, tx_valid, output sample_in, tx_ready);
endinterface

// File: rtl/wave_stream_scheduler.sv
// Paces the waveform generator with a programmable divider and frames each
// 10-bit sample as header/high/low bytes for the UART transmitter.
module wave_stream_scheduler #(
  parameter int unsigned DIV_W    = 16,
  parameter logic [7:0]  HDR_BYTE = 8'hA5,
  parameter int unsigned OVR_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [DIV_W-1:0]         rate_div,
  wave_stream_scheduler_if.master  bus,
  output logic                     busy,
  output logic                     overrun,
  output logic [OVR_W-1:0]         ovr_count,
  output logic [15:0]              frame_count
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CAPTURE, S_HDR, S_HI, S_LO} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [9:0]       smp_q, smp_d;
  logic [7:0]       txd_q, txd_d;
  logic             txv_q, txv_d;
  logic             ovr_q, ovr_d;
  logic [OVR_W-1:0] ovc_q, ovc_d;
  logic [15:0]      frm_q, frm_d;
  logic             tick, xfer, in_frame, gen_ce;

  assign in_frame = state_q inside {S_CAPTURE, S_HDR, S_HI, S_LO};
  assign xfer     = txv_q && bus.tx_ready;

  // The divider free-runs while enabled regardless of FSM state, so skipped
  // ticks stay on the same sample grid.
  always_comb begin
    tick  = enable && (cnt_q == div_q);
    cnt_d = cnt_q + DIV_W'(1);
    div_d = div_q;
    if (!enable || tick) begin
      cnt_d = '0;
      div_d = rate_div;
    end
  end

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    ovr_d   = ovr_q;
    ovc_d   = ovc_q;
    frm_d   = frm_q;
    gen_ce  = 1'b0;
    case (state_q)
      S_IDLE: if (enable) state_d = S_WAIT;
      S_WAIT: begin
        if (tick) begin
          gen_ce  = 1'b1;
          state_d = S_CAPTURE;
        end else if (!enable) begin
          state_d = S_IDLE;
        end
      end
      S_CAPTURE: begin
        smp_d   = bus.sample_in;
        txd_d   = HDR_BYTE;
        txv_d   = 1'b1;
        state_d = S_HDR;
      end
      S_HDR: if (xfer) begin
        txd_d   = {{6{smp_q[9]}}, smp_q[9:8]};
        state_d = S_HI;
      end
      S_HI: if (xfer) begin
        txd_d   = smp_q[7:0];
        state_d = S_LO;
      end
      S_LO: if (xfer) begin
        txd_d   = '0;
        txv_d   = 1'b0;
        frm_d   = frm_q + 16'd1;
        state_d = enable ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A tick that lands while a frame is in flight is dropped, never queued.
    if (tick && in_frame) begin
      ovr_d = 1'b1;
      if (ovc_q != '1) ovc_d = ovc_q + OVR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      smp_q   <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ovc_q   <= '0;
      frm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      smp_q   <= smp_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      ovr_q   <= ovr_d;
      ovc_q   <= ovc_d;
      frm_q   <= frm_d;
    end
  end

  assign bus.gen_ce   = gen_ce;
  assign bus.tx_data  = txd_q;
  assign bus.tx_valid = txv_q;
  assign busy         = in_frame;
  assign overrun      = ovr_q;
  assign ovr_count    = ovc_q;
  assign frame_count  = frm_q;

endmodule

// File: tb/tb_wave_stream_scheduler.sv
// Directed phases with randomized ready/rate/enable, checked every cycle against
// a frame-level model: tick timestamps, a sample scoreboard and byte framing.
module tb_wave_stream_scheduler;
  localparam int DIV_W = 16;
  localparam int OVR_W = 8;
  localparam int OVR_MAX = (1 << OVR_W) - 1;
  localparam int M_IDLE = 0, M_WAIT = 1, M_FRAME = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [DIV_W-1:0] rate_div = '0;
  logic             busy, overrun;
  logic [OVR_W-1:0] ovr_count;
  logic [15:0]      frame_count;

  wave_stream_scheduler_if bus();

  wave_stream_scheduler #(.DIV_W(DIV_W), .HDR_BYTE(8'hA5), .OVR_W(OVR_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rate_div(rate_div), .bus(bus),
    .busy(busy), .overrun(overrun), .ovr_count(ovr_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state
  int     m_st, m_nbytes, m_ovr, m_frames;
  bit     m_first, m_ovr_flag, m_fresh;
  longint cyc_no = 0, next_tick = 0;
  int     exp_q[$];
  int     gen_idx = 0, fix_val = 0, gen_seen = 0;
  bit     adv, fix_en, prev_stall;
  longint last_gen_cyc = 0, gen_gap = 0;
  logic [7:0] prev_data;
  logic [7:0] last_bytes [3];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int gen_val(int n);
    int x;
    x = (n % 64) - 32;
    return x * x / 2 - 256;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_nbytes = 0; m_first = 0; m_ovr = 0; m_ovr_flag = 0;
    m_frames = 0; exp_q.delete(); adv = 0; prev_stall = 0; m_fresh = 1;
  endtask

  task automatic monitor();
    bit tick, eg, ev, hs;
    int s;
    logic [7:0] eb;
    if (!rst_n) begin
      model_reset();
      cyc_no++;
      return;
    end
    if (m_fresh) begin next_tick = cyc_no; m_fresh = 0; end
    tick = enable && (cyc_no == next_tick);
    eg = (m_st == M_WAIT) && tick;
    ev = (m_st == M_FRAME) && !m_first;
    chk("gen_ce", bus.gen_ce, eg);
    chk("busy", busy, m_st == M_FRAME);
    chk("tx_valid", bus.tx_valid, ev);
    chk("ovr_count", ovr_count, m_ovr);
    chk("overrun", overrun, m_ovr_flag);
    chk("frame_count", frame_count, m_frames & 16'hFFFF);
    if (prev_stall) chk("stall_hold", bus.tx_data, prev_data);
    hs = ev && bus.tx_ready;
    prev_stall = ev && !bus.tx_ready;
    prev_data = bus.tx_data;
    if (bus.gen_ce) begin
      adv = 1; gen_seen++; gen_gap = cyc_no - last_gen_cyc; last_gen_cyc = cyc_no;
    end
    if (m_st == M_FRAME && tick) begin
      m_ovr = (m_ovr < OVR_MAX) ? m_ovr + 1 : OVR_MAX;
      m_ovr_flag = 1;
    end
    if (hs) begin
      s = (exp_q.size() > 0) ? exp_q[0] : 0;
      case (m_nbytes)
        0:       eb = 8'hA5;
        1:       eb = 8'((s >>> 8) & 255);
        default: eb = 8'(s & 255);
      endcase
      chk("tx_byte", bus.tx_data, eb);
      if (m_nbytes < 3) last_bytes[m_nbytes] = bus.tx_data;
      m_nbytes++;
    end
    case (m_st)
      M_IDLE: if (enable) m_st = M_WAIT;
      M_WAIT: begin
        if (tick) begin m_st = M_FRAME; m_first = 1; m_nbytes = 0; end
        else if (!enable) m_st = M_IDLE;
      end
      default: begin
        m_first = 0;
        if (hs && m_nbytes == 3) begin
          m_frames++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_st = enable ? M_WAIT : M_IDLE;
        end
      end
    endcase
    if (!enable || tick) next_tick = cyc_no + 1 + longint'(rate_div);
    cyc_no++;
  endtask

  // One clock: observe the settled cycle, then advance the generator model on the edge.
  task automatic cyc();
    int v;
    #1;
    monitor();
    @(posedge clk);
    #1;
    if (adv) begin
      adv = 0;
      gen_idx++;
      v = fix_en ? fix_val : gen_val(gen_idx);
      bus.sample_in = 10'(v);
      exp_q.push_back(v);
    end
  endtask

  initial begin
    int g0, n;
    logic [15:0] f0;
    logic [OVR_W-1:0] o0;
    bus.tx_ready = 1'b0;
    bus.sample_in = '0;
    model_reset();

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gen_ce", bus.gen_ce, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ovr_count", ovr_count, 0);
    chk("rst_frame_count", frame_count, 0);

    // basic frame, first sample forced to -3
    rst_n = 1; rate_div = 9; bus.tx_ready = 1; fix_en = 1; fix_val = -3; enable = 1;
    for (int i = 0; i < 100 && m_frames < 1; i++) cyc();
    chk("basic_frame_done", m_frames, 1);
    chk("basic_b0", last_bytes[0], 8'hA5);
    chk("basic_b1", last_bytes[1], 8'hFF);
    chk("basic_b2", last_bytes[2], 8'hFD);
    fix_en = 0;
    repeat (30) cyc();
    chk("basic_gen_enough", gen_seen >= 3, 1);
    chk("basic_period", gen_gap, 10);

    // back-pressure in HI once the new period is latched
    rate_div = 99;
    g0 = gen_seen;
    for (int i = 0; i < 300 && gen_seen < g0 + 2; i++) cyc();
    chk("bp_reached", gen_seen >= g0 + 2, 1);
    for (int i = 0; i < 20 && !(m_st == M_FRAME && m_nbytes == 1); i++) cyc();
    chk("bp_in_hi", m_st == M_FRAME && m_nbytes == 1, 1);
    bus.tx_ready = 0; g0 = gen_seen; f0 = frame_count;
    repeat (5) cyc();
    chk("bp_no_gen", gen_seen - g0, 0);
    chk("bp_hi_byte", bus.tx_data, 8'((exp_q[0] >>> 8) & 255));
    chk("bp_valid_held", bus.tx_valid, 1);
    bus.tx_ready = 1;
    repeat (5) cyc();
    chk("bp_one_frame", frame_count, 16'(f0 + 16'd1));

    // overrun at rate_div = 1
    rate_div = 1; o0 = ovr_count; g0 = gen_seen;
    repeat (160) cyc();
    chk("ovr_flag", overrun, 1);
    chk("ovr_grew", ovr_count > o0, 1);
    chk("ovr_gens", gen_seen - g0 >= 10, 1);

    // enable drop during HDR
    rate_div = 5;
    for (int i = 0; i < 50 && !(m_st == M_FRAME && !m_first && m_nbytes == 0); i++) cyc();
    chk("drop_in_hdr", m_st == M_FRAME && !m_first && m_nbytes == 0, 1);
    enable = 0; g0 = gen_seen; f0 = frame_count;
    repeat (20) cyc();
    chk("drop_no_gen", gen_seen - g0, 0);
    chk("drop_frame_done", frame_count, 16'(f0 + 16'd1));
    chk("drop_idle", busy, 0);
    enable = 1; g0 = gen_seen; n = -1;
    for (int i = 0; i < 40 && n < 0; i++) begin
      cyc();
      if (gen_seen != g0) n = i;
    end
    chk("reenable_latency", n, 5);

    // saturate ovr_count with a stall at rate_div = 0
    rate_div = 0; bus.tx_ready = 0;
    for (int i = 0; i < 50 && !(m_st == M_FRAME && !m_first); i++) cyc();
    repeat (300) cyc();
    chk("sat_value", ovr_count, OVR_MAX);
    repeat (20) cyc();
    chk("sat_hold", ovr_count, OVR_MAX);
    bus.tx_ready = 1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) rate_div = DIV_W'($urandom_range(0, 12));
      enable = ($urandom_range(0, 24) != 0);
      cyc();
    end

    // async reset while stalled in LO
    enable = 1; rate_div = 3; bus.tx_ready = 1;
    for (int i = 0; i < 100 && !(m_st == M_FRAME && m_nbytes == 2); i++) cyc();
    chk("ar_in_lo", m_st == M_FRAME && m_nbytes == 2, 1);
    bus.tx_ready = 0;
    repeat (2) cyc();
    #2 rst_n = 0;
    #1;
    chk("ar_tx_valid", bus.tx_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_frame_count", frame_count, 0);
    chk("ar_ovr_count", ovr_count, 0);
    chk("ar_overrun", overrun, 0);
    repeat (2) cyc();
    rate_div = 7; enable = 1; bus.tx_ready = 1; rst_n = 1;
    g0 = gen_seen; n = -1;
    for (int i = 0; i < 40 && n < 0; i++) begin
      cyc();
      if (gen_seen != g0) n = i;
    end
    chk("ar_first_gen", n, 8);
    repeat (20) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
